// File: rtl/global_defs_pkg.sv
// Shared definitions for the trace-driven DRAM model.
// The request queue reuses parsed_op_t and ADDRESS_WIDTH and adds its entry type.
package global_defs;

  localparam int ADDRESS_WIDTH       = 32;
  localparam int QUEUE_DEPTH_DEFAULT = 16;
  localparam int AGE_WIDTH_DEFAULT   = 16;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } parsed_op_t;

  typedef struct packed {
    parsed_op_t                     op;
    logic [ADDRESS_WIDTH-1:0]       addr;
    logic [AGE_WIDTH_DEFAULT-1:0]   age;
  } queue_entry_t;

endpackage

// File: rtl/request_queue.sv
// In-order request buffer between the trace parser and the DRAM command scheduler.
// Each entry carries opcode, address and a saturating wait-age counter.
module request_queue
  import global_defs::*;
#(
  parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT,
  parameter int AGE_WIDTH   = AGE_WIDTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  parsed_op_t                   in_op,
  input  logic [ADDRESS_WIDTH-1:0]     in_addr,
  output logic                         in_ready,
  output logic                         out_valid,
  output parsed_op_t                   out_op,
  output logic [ADDRESS_WIDTH-1:0]     out_addr,
  output logic [AGE_WIDTH-1:0]         out_age,
  input  logic                         out_ready,
  output logic [$clog2(QUEUE_DEPTH):0] count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("request_queue: QUEUE_DEPTH must be a power of two, at least 2");
  end

  function automatic logic [AGE_WIDTH-1:0] sat_age_inc(input logic [AGE_WIDTH-1:0] age);
    return (&age) ? age : age + 1'b1;
  endfunction

  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_tail;
  logic [CNT_W-1:0]         r_count;
  parsed_op_t               r_op   [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_addr [QUEUE_DEPTH];
  logic [AGE_WIDTH-1:0]     r_age  [QUEUE_DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Ready comes only from registered occupancy, so a pop never frees a slot same-cycle.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid && !w_full && (in_op != NOP);
  assign w_pop   = out_ready && !w_empty;

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;

  // Control state: pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Entry storage and ages; free slots also age, but are reloaded with 0 on push
  always_ff @(posedge clk) begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      r_age[i] <= sat_age_inc(r_age[i]);
    end
    if (w_push) begin
      r_op[r_tail]   <= in_op;
      r_addr[r_tail] <= in_addr;
      r_age[r_tail]  <= '0;
    end
  end

  always_comb begin
    out_op   = NOP;
    out_addr = '0;
    out_age  = '0;
    if (!w_empty) begin
      out_op   = r_op[r_head];
      out_addr = r_addr[r_head];
      out_age  = r_age[r_head];
    end
  end

endmodule

// File: tb/tb_request_queue.sv
// Directed bench for request_queue: a default instance and a 4-bit-age instance
// share all inputs so age saturation is visible alongside normal behaviour.
module tb_request_queue;
  import global_defs::*;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     in_valid = 1'b0;
  parsed_op_t               in_op = NOP;
  logic [ADDRESS_WIDTH-1:0] in_addr = '0;
  logic                     out_ready = 1'b0;

  logic                     in_ready, out_valid, full, empty;
  parsed_op_t               out_op;
  logic [ADDRESS_WIDTH-1:0] out_addr;
  logic [15:0]              out_age;
  logic [4:0]               count;

  logic                     s_in_ready, s_out_valid, s_full, s_empty;
  parsed_op_t               s_out_op;
  logic [ADDRESS_WIDTH-1:0] s_out_addr;
  logic [3:0]               s_out_age;
  logic [4:0]               s_count;

  int n_checks = 0;
  int n_fail   = 0;

  request_queue #(.QUEUE_DEPTH(16), .AGE_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
    .in_ready(in_ready), .out_valid(out_valid), .out_op(out_op), .out_addr(out_addr),
    .out_age(out_age), .out_ready(out_ready), .count(count), .full(full), .empty(empty)
  );

  request_queue #(.QUEUE_DEPTH(16), .AGE_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_op(s_out_op), .out_addr(s_out_addr),
    .out_age(s_out_age), .out_ready(out_ready), .count(s_count), .full(s_full), .empty(s_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input parsed_op_t op, input logic [ADDRESS_WIDTH-1:0] addr);
    in_valid = 1'b1; in_op = op; in_addr = addr;
    tick();
    in_valid = 1'b0; in_op = NOP; in_addr = '0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_hold_empty: got %b expected 1", empty); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_hold_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0;
    tick();
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_op !== NOP) begin n_fail++; $display("FAIL reset_out_op: got %0d expected %0d", out_op, NOP); end
    n_checks++; if (out_addr !== 32'h0) begin n_fail++; $display("FAIL reset_out_addr: got %h expected 0", out_addr); end
    n_checks++; if (out_age !== 16'd0) begin n_fail++; $display("FAIL reset_out_age: got %0d expected 0", out_age); end
  endtask

  task automatic test_single();
    push_one(READ, 32'h1A2B3C4D);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_addr !== 32'h1A2B3C4D) begin n_fail++; $display("FAIL single_addr: got %h expected 1a2b3c4d", out_addr); end
    n_checks++; if (out_op !== READ) begin n_fail++; $display("FAIL single_op: got %0d expected %0d", out_op, READ); end
    n_checks++; if (out_age !== 16'd0) begin n_fail++; $display("FAIL single_age0: got %0d expected 0", out_age); end
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
    repeat (3) tick();
    n_checks++; if (out_age !== 16'd3) begin n_fail++; $display("FAIL single_age3: got %0d expected 3", out_age); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_pop_empty: got %b expected 1", empty); end
    n_checks++; if (out_addr !== 32'h0) begin n_fail++; $display("FAIL single_pop_addr: got %h expected 0", out_addr); end
    tick();
    out_ready = 1'b0;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL pop_while_empty_count: got %0d expected 0", count); end
  endtask

  task automatic test_fill_stall();
    logic [ADDRESS_WIDTH-1:0] exp_addr;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_op = WRITE; in_addr = 32'h1000 + i;
      tick();
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", full); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d expected 16", count); end
    in_addr = 32'h2000;
    repeat (2) tick();
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL stall_count: got %0d expected 16", count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (count !== 5'd15) begin n_fail++; $display("FAIL full_pop_count: got %0d expected 15", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_addr !== 32'h1001) begin n_fail++; $display("FAIL full_pop_head: got %h expected 1001", out_addr); end
    tick();
    in_valid = 1'b0; in_op = NOP; in_addr = '0;
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL late_push_count: got %0d expected 16", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_addr = (i < 15) ? 32'h1001 + i : 32'h2000;
      n_checks++; if (out_addr !== exp_addr) begin n_fail++; $display("FAIL drain_addr[%0d]: got %h expected %h", i, out_addr, exp_addr); end
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", empty); end
  endtask

  task automatic test_order_wrap();
    logic [ADDRESS_WIDTH-1:0] exp_q[$];
    int pushed = 0;
    int popped = 0;
    logic do_push, do_pop;
    for (int c = 0; c < 300 && popped < 40; c++) begin
      do_push = (pushed < 40) && (exp_q.size() < 16) && ((c % 3) != 2);
      do_pop  = ((exp_q.size() > 1) || (pushed == 40 && exp_q.size() > 0)) && ((c % 4) != 0);
      if (do_pop) begin
        n_checks++; if (out_addr !== exp_q[0]) begin n_fail++; $display("FAIL order_addr[%0d]: got %h expected %h", popped, out_addr, exp_q[0]); end
      end
      in_valid  = do_push;
      in_op     = do_push ? READ : NOP;
      in_addr   = 32'hA000_0000 + pushed * 32'h111;
      out_ready = do_pop;
      tick();
      if (do_pop) begin
        void'(exp_q.pop_front());
        popped++;
      end
      if (do_push) begin
        exp_q.push_back(32'hA000_0000 + pushed * 32'h111);
        pushed++;
      end
      n_checks++; if (count !== 5'(exp_q.size())) begin n_fail++; $display("FAIL order_count: got %0d expected %0d", count, exp_q.size()); end
    end
    in_valid = 1'b0; in_op = NOP; out_ready = 1'b0;
    n_checks++; if (popped != 40) begin n_fail++; $display("FAIL order_timeout: popped %0d expected 40", popped); end
  endtask

  task automatic test_simul_push_pop();
    for (int i = 0; i < 5; i++) push_one(READ, 32'hB0 + i);
    n_checks++; if (count !== 5'd5) begin n_fail++; $display("FAIL simul_pre_count: got %0d expected 5", count); end
    in_valid = 1'b1; in_op = WRITE; in_addr = 32'hB5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_op = NOP; in_addr = '0; out_ready = 1'b0;
    n_checks++; if (count !== 5'd5) begin n_fail++; $display("FAIL simul_count: got %0d expected 5", count); end
    n_checks++; if (out_addr !== 32'hB1) begin n_fail++; $display("FAIL simul_head: got %h expected b1", out_addr); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_addr !== 32'hB1 + i) begin n_fail++; $display("FAIL simul_drain[%0d]: got %h expected %h", i, out_addr, 32'hB1 + i); end
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL simul_empty: got %b expected 1", empty); end
  endtask

  task automatic test_nop();
    push_one(READ, 32'hC0);
    push_one(WRITE, 32'hC1);
    in_valid = 1'b1; in_op = NOP; in_addr = 32'hDEAD;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL nop_in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0; in_addr = '0;
    n_checks++; if (count !== 5'd2) begin n_fail++; $display("FAIL nop_count: got %0d expected 2", count); end
    out_ready = 1'b1;
    n_checks++; if (out_addr !== 32'hC0) begin n_fail++; $display("FAIL nop_head0: got %h expected c0", out_addr); end
    tick();
    n_checks++; if (out_addr !== 32'hC1) begin n_fail++; $display("FAIL nop_head1: got %h expected c1", out_addr); end
    tick();
    out_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL nop_empty: got %b expected 1", empty); end
  endtask

  task automatic test_age_saturation();
    push_one(READ, 32'hE0);
    n_checks++; if (s_out_age !== 4'd0) begin n_fail++; $display("FAIL sat_age0: got %0d expected 0", s_out_age); end
    repeat (20) tick();
    n_checks++; if (s_out_age !== 4'd15) begin n_fail++; $display("FAIL sat_age: got %0d expected 15", s_out_age); end
    n_checks++; if (out_age !== 16'd20) begin n_fail++; $display("FAIL wide_age: got %0d expected 20", out_age); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (s_empty !== 1'b1) begin n_fail++; $display("FAIL sat_pop_empty: got %b expected 1", s_empty); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) push_one(WRITE, 32'hF0 + i);
    n_checks++; if (count !== 5'd7) begin n_fail++; $display("FAIL areset_pre_count: got %0d expected 7", count); end
    #2;
    rst = 1'b1; in_valid = 1'b1; in_op = READ; in_addr = 32'hF9;
    #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL areset_empty: got %b expected 1", empty); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL areset_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (s_empty !== 1'b1) begin n_fail++; $display("FAIL areset_sat_empty: got %b expected 1", s_empty); end
    tick();
    rst = 1'b0; in_valid = 1'b0; in_op = NOP; in_addr = '0;
    tick();
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL areset_post_count: got %0d expected 0", count); end
    push_one(READ, 32'h55);
    n_checks++; if (out_addr !== 32'h55) begin n_fail++; $display("FAIL areset_recover_addr: got %h expected 55", out_addr); end
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL areset_recover_count: got %0d expected 1", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_order_wrap();
    test_simul_push_pop();
    test_nop();
    test_age_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
